// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier control.
// The STEP state is only reachable when ADD_SHIFT_MERGE_EN is defined.
package mult_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_ADD   = 3'd3,
      ST_SHIFT = 3'd4,
      ST_STEP  = 3'd5,
      ST_DONE  = 3'd6
   } seq_state_t;

   // Counter width able to hold the value w itself.
   function automatic int cnt_w_f(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/iter_counter.sv
// Loadable down-counter for the iteration count, with zero/one flags.
// Saturates at zero so a stray dec never wraps.
module iter_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             is_zero,
   output logic             is_one
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign is_zero = (count == '0);
   assign is_one  = (count == CNT_W'(1));

endmodule

// File: rtl/shift_add_sequencer.sv
// Control FSM for the shift-and-add multiplier datapath.
// Build option ADD_SHIFT_MERGE_EN folds CHECK/ADD/SHIFT into one STEP state.
//
// state | meaning
// IDLE  | waiting for start, ready high
// LOAD  | load B and Q, clear {E,A}, count <- WIDTH
// CHECK | inspect q0 to choose ADD or SHIFT
// ADD   | capture A + B into {E,A}
// SHIFT | right-shift {E,A,Q}, count down
// STEP  | merged add (if q0) and shift in one cycle
// DONE  | one-cycle completion pulse
module shift_add_sequencer
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = cnt_w_f(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             q0,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             ld_b,
   output logic             q_lds,
   output logic             q_ebl,
   output logic             a_clr,
   output logic             add_en,
   output logic             shift_en,
   output logic [CNT_W-1:0] count
);

   seq_state_t state, state_next;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;
   logic       cnt_one;

   iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (CNT_W'(WIDTH)),
      .count    (count),
      .is_zero  (cnt_zero),
      .is_one   (cnt_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      ld_b       = 1'b0;
      q_lds      = 1'b0;
      q_ebl      = 1'b0;
      a_clr      = 1'b0;
      add_en     = 1'b0;
      shift_en   = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            busy     = 1'b1;
            ld_b     = 1'b1;
            q_lds    = 1'b1;
            q_ebl    = 1'b1;
            a_clr    = 1'b1;
            cnt_load = 1'b1;
`ifdef ADD_SHIFT_MERGE_EN
            state_next = ST_STEP;
`else
            state_next = ST_CHECK;
`endif
         end
`ifdef ADD_SHIFT_MERGE_EN
         ST_STEP: begin
            // add_en follows q0 directly; the datapath shifts the sum on the same edge
            busy       = 1'b1;
            shift_en   = 1'b1;
            q_ebl      = 1'b1;
            add_en     = q0;
            cnt_dec    = 1'b1;
            state_next = (cnt_one || cnt_zero) ? ST_DONE : ST_STEP;
         end
`else
         ST_CHECK: begin
            busy       = 1'b1;
            state_next = q0 ? ST_ADD : ST_SHIFT;
         end
         ST_ADD: begin
            busy       = 1'b1;
            add_en     = 1'b1;
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy       = 1'b1;
            shift_en   = 1'b1;
            q_ebl      = 1'b1;
            cnt_dec    = 1'b1;
            state_next = (cnt_one || cnt_zero) ? ST_DONE : ST_CHECK;
         end
`endif
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (abort) state_next = ST_IDLE;
   end

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Directed bench for shift_add_sequencer with a behavioural {E,A,Q} datapath.
// Expectations switch with ADD_SHIFT_MERGE_EN to match the build under test.
module tb_shift_add_sequencer;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             q0;
   logic             ready, busy, done, ld_b, q_lds, q_ebl, a_clr, add_en, shift_en;
   logic [CNT_W-1:0] count;

   logic [7:0] mcand = 8'h00;
   logic [7:0] mplier = 8'h00;
   logic [7:0] reg_b, reg_a, reg_q;
   logic       reg_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_add_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .q0       (q0),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .ld_b     (ld_b),
      .q_lds    (q_lds),
      .q_ebl    (q_ebl),
      .a_clr    (a_clr),
      .add_en   (add_en),
      .shift_en (shift_en),
      .count    (count)
   );

   assign q0 = reg_q[0];

   // Datapath model: in the merged build add_en and shift_en coincide and the sum is shifted.
   always_ff @(posedge clk) begin
      logic [8:0] sum;
      sum = add_en ? ({1'b0, reg_a} + {1'b0, reg_b}) : {reg_e, reg_a};
      if (ld_b) reg_b <= mcand;
      if (q_ebl && q_lds) reg_q <= mplier;
      if (a_clr) begin
         reg_e <= 1'b0;
         reg_a <= 8'h00;
      end else if (shift_en) begin
         {reg_e, reg_a, reg_q} <= {1'b0, sum, reg_q} >> 1;
      end else if (add_en) begin
         {reg_e, reg_a} <= sum;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] outs_vec();
      return {busy, done, ld_b, q_lds, q_ebl, a_clr, add_en, shift_en, ready};
   endfunction

   task automatic run_op(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                         input bit hold, input int exp_done);
      int done_cyc = -1;
      int n_ld = 0;
      int n_shift = 0;
      int add_mask = 0;
      int excl = 0;
      @(negedge clk);
      mcand  = mc;
      mplier = mp;
      start  = 1'b1;
      for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            chk({tag, "_load_c1"}, {31'd0, ld_b}, 32'd1);
            chk({tag, "_ready_c1"}, {31'd0, ready}, 32'd0);
            if (!hold) start = 1'b0;
         end
         if (cyc == 2) chk({tag, "_count_c2"}, {28'd0, count}, WIDTH);
         n_ld += int'(ld_b);
         if (add_en) add_mask |= (1 << n_shift);
         if (shift_en) n_shift++;
`ifndef ADD_SHIFT_MERGE_EN
         if ((int'(ld_b) + int'(add_en) + int'(shift_en)) > 1) excl++;
`endif
         if (done) done_cyc = cyc;
      end
      chk({tag, "_done_cycle"}, done_cyc, exp_done);
      chk({tag, "_shifts"}, n_shift, WIDTH);
      chk({tag, "_add_steps"}, add_mask, {24'd0, mp});
      chk({tag, "_loads"}, n_ld, 1);
      chk({tag, "_excl"}, excl, 0);
      chk({tag, "_product"}, {16'd0, reg_a, reg_q}, 32'(16'(mc) * 16'(mp)));
      @(negedge clk);
      chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
      chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
      if (hold) begin
         @(negedge clk);
         chk({tag, "_reload"}, {31'd0, ld_b}, 32'd1);
         start = 1'b0;
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         chk({tag, "_abort_idle"}, {31'd0, ready}, 32'd1);
      end
   endtask

   initial begin
      int n_done;
      #1;
      chk("reset_outs", {23'd0, outs_vec()}, 32'h001);
      chk("reset_count", {28'd0, count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef ADD_SHIFT_MERGE_EN
      run_op("zero", 8'h00, 8'h00, 1'b0, 10);
      run_op("ff", 8'hFF, 8'hFF, 1'b0, 10);
      run_op("m13x11", 8'd13, 8'd11, 1'b0, 10);
      run_op("hold", 8'h05, 8'h00, 1'b1, 10);
`else
      run_op("zero", 8'h00, 8'h00, 1'b0, 18);
      run_op("ff", 8'hFF, 8'hFF, 1'b0, 26);
      run_op("m13x11", 8'd13, 8'd11, 1'b0, 21);
      run_op("hold", 8'h05, 8'h00, 1'b1, 18);
`endif

      // start together with abort in IDLE is not accepted
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_idle_start", {31'd0, ready}, 32'd1);
      start = 1'b0;
      abort = 1'b0;

      // abort raised in cycle 5
      mplier = 8'hA5;
      start  = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
      end
      chk("abort_busy_c5", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_outs_c6", {23'd0, outs_vec()}, 32'h001);
      n_done = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         n_done += int'(done);
      end
      chk("abort_no_done", n_done, 0);

      // reset pulse while in SHIFT
      mplier = 8'h00;
      start  = 1'b1;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
      end
      chk("rst_in_shift", {31'd0, shift_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {23'd0, outs_vec()}, 32'h001);
      chk("rst_mid_count", {28'd0, count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         n_done += int'(done) + int'(busy);
      end
      chk("rst_no_resume", n_done, 0);
      chk("rst_ready", {31'd0, ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
